// File: rtl/program_loader.sv
// program_loader: boot-time loader that streams a length-prefixed, checksummed
// image from a host into instruction memory, pads the rest with NOP_WORD and
// holds the CPU in reset until a verified image is in place.

`ifndef NOP
`define NOP 16'h0000
`endif

module program_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [15:0] NOP_WORD   = `NOP
) (
  input  logic        clk,
  input  logic        pc_reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] checksum
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LAST_C  = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHECK,
    S_PAD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic [15:0]           sum_q, sum_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [15:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  hs;

  assign in_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign hs         = in_valid & in_ready;
  assign addr_inc   = addr_q + ONE_C;

  assign imem_we    = imem_we_q;
  assign imem_addr  = {{(16 - ADDR_WIDTH){1'b0}}, imem_addr_q};
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign checksum   = sum_q;

  // Next-state and registered-output logic for the load sequence.
  // RUN keeps re-asserting done/release so that entering RUN from PAD
  // delays the release by one edge, after the last pad write has committed.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    addr_d       = addr_q;
    sum_d        = sum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (hs) begin
          if ((in_data == 16'd0) || (in_data > 16'(DEPTH_C))) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            len_d   = in_data[ADDR_WIDTH:0];
            addr_d  = '0;
            sum_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = addr_q[ADDR_WIDTH-1:0];
          imem_wdata_d = in_data;
          sum_d        = sum_q + in_data;
          addr_d       = addr_inc;
          if (addr_inc == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hs) begin
          if (in_data == sum_q) begin
            if (len_q == DEPTH_C) begin
              state_d     = S_RUN;
              cpu_reset_d = 1'b0;
              done_d      = 1'b1;
            end else begin
              state_d = S_PAD;
            end
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      S_PAD: begin
        imem_we_d    = 1'b1;
        imem_addr_d  = addr_q[ADDR_WIDTH-1:0];
        imem_wdata_d = NOP_WORD;
        addr_d       = addr_inc;
        if (addr_q == LAST_C) state_d = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          state_d     = S_LEN;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
        end else begin
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      S_ERROR: begin
        if (start) begin
          state_d = S_LEN;
          error_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset; a write issued on
  // the reset edge is dropped because imem_we_q is forced low.
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      sum_q        <= sum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the 16-bit pipelined CPU. It accepts a length-prefixed, checksummed word stream from a host over a valid/ready handshake and writes it into instruction memory through that memory's write port. It pads any unused instruction memory with `nop` and holds the CPU in reset through its `pc_reset` input until a verified image is in place. It then releases the CPU and reports `done`, or reports `error` and keeps the CPU in reset.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: instruction memory address bits; DEPTH = 2**ADDR_WIDTH; legal range 1..15.
- `NOP_WORD`, `` `nop `` (ISA nop encoding from the shared define file): fill word written to unused locations.

Ports:
- `clk`  in  1  single clock, rising edge.
- `pc_reset`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a load.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  loader accepts a word.
- `in_data`  in  16  host word.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  16  write address; bits above ADDR_WIDTH-1 are always 0.
- `imem_wdata`  out  16  write data.
- `cpu_reset`  out  1  drives the CPU `pc_reset`; high holds the CPU in reset.
- `done`  out  1  a verified image is loaded and the CPU is running.
- `error`  out  1  the last load failed.
- `checksum`  out  16  running 16-bit sum of the program words accepted in the current load.

## Operation
- A handshake is `in_valid & in_ready` at a rising edge.
- Stream format: one length word N, then N program words, then one checksum word.
- The checksum word must equal the sum of the program words modulo 2^16. The length word is not included in the sum.
- States:
  - IDLE: reset state; `in_ready` = 0; `start` -> LEN.
  - LEN: `in_ready` = 1. On handshake, N == 0 or N > DEPTH -> ERROR. Otherwise latch N, clear the address counter and sum, -> DATA.
  - DATA: `in_ready` = 1. Each handshake issues a write of `in_data` to the current address, adds `in_data` to the sum and increments the address. The handshake that completes word N -> CHECK.
  - CHECK: `in_ready` = 1. On handshake, `in_data` == sum -> PAD if N < DEPTH, or RUN if N == DEPTH. A mismatch -> ERROR.
  - PAD: `in_ready` = 0. Writes `NOP_WORD` to addresses N..DEPTH-1, one per cycle, then -> RUN.
  - RUN: `cpu_reset` = 0, `done` = 1. `start` -> LEN.
  - ERROR: `error` = 1, `cpu_reset` = 1. `start` -> LEN.
- `start` is ignored in LEN, DATA, CHECK and PAD.
- Entering LEN from RUN or ERROR:
  - `cpu_reset` rises and `done`/`error` clear on the next edge.
  - `checksum` clears when the length word is accepted.
- `in_ready` is combinational from state only and never depends on `in_valid`.
- Arithmetic rules:
  - The sum is a 16-bit accumulator; carry is discarded.
  - The address counter is ADDR_WIDTH+1 bits so that N == DEPTH terminates cleanly.
  - N is compared as an unsigned 16-bit value.
- `pc_reset` in any state:
  - -> IDLE on that edge; outputs take their reset values.
  - A write issued on the reset edge is dropped: `imem_we` = 0 in the following cycle.

## Timing
- Reset values:
  - `cpu_reset` = 1.
  - `done`, `error`, `imem_we` = 0.
  - `imem_addr`, `imem_wdata`, `checksum` = 0.
  - `in_ready` = 0 (IDLE).
- `imem_we`, `imem_addr`, `imem_wdata`, `cpu_reset`, `done`, `error` and `checksum` are all registered.
- Write latency: a DATA handshake at edge t presents `imem_we` = 1 with that address and data in cycle t+1. `imem_we` is 0 in every cycle with no issued write.
- Throughput is one word per cycle with `in_valid` held high. Gaps in `in_valid` stall without losing state.
- PAD takes exactly DEPTH-N cycles of consecutive writes.
- RUN release: `cpu_reset` falls and `done` rises on the edge after the cycle carrying the last `imem_we` pulse. The CPU therefore never fetches before the final write commits.
- `error` rises on the edge after the rejecting handshake. No PAD writes occur on an error path.
- Minimum load time with no stalls: 1 (start) + 1 (length) + N (data) + 1 (checksum) + (DEPTH-N) (pad) + 1 (release) cycles.

## Test plan
All scenarios use ADDR_WIDTH = 3 (DEPTH = 8).
1. Reset: assert `pc_reset` for 1 cycle mid-stream -> next cycle `cpu_reset`=1, `done`=0, `error`=0, `imem_we`=0, `in_ready`=0, `checksum`=0.
2. Happy path: start; stream 3, 0x1111, 0x2222, 0x3333, 0x6666 -> writes to addr 0..2 with those values, then `NOP_WORD` to addr 3..7 on 5 consecutive cycles, then `cpu_reset`=0, `done`=1, `checksum`=0x6666.
3. Bad checksum: same stream but with checksum word 0x6667 -> `error`=1, `cpu_reset` stays 1, no writes after addr 2. A following `start` plus a correct stream -> `done`=1, `error`=0.
4. Illegal length: length word 0 -> `error`=1 with no writes. Length word 9 -> `error`=1 with no writes.
5. Full image with wrap: length 8, eight words of 0xFFFF, checksum 0xFFF8 -> 8 writes, no PAD, `done`=1 one edge after the last write. Then `start` in RUN -> `cpu_reset`=1 and `done`=0 on the next edge.
6. Backpressure: `in_valid` toggling 1,0,0,1 per word -> identical write sequence and result to scenario 2. Writes occur only one cycle after each handshake. `start` pulsed during DATA has no effect.
